// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its shared-ALU datapath.
// The master modport is the controller; the slave modport is the datapath/memory side.
interface multicycle_control_if;
  logic [31:0] ins;
  logic        mem_ready;
  logic        mem_req;
  logic        memWrite;
  logic        IorD;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [1:0]  PCSource;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [4:0]  ALUControl;
  logic        regWriteEnable;
  logic [1:0]  regDst;
  logic [1:0]  memToReg;
  logic        illegal;
  logic [3:0]  state;

  modport master (
    input  ins, mem_ready,
    output mem_req, memWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
           ALUSrcA, ALUSrcB, ALUControl, regWriteEnable, regDst, memToReg,
           illegal, state
  );

  modport slave (
    output ins, mem_ready,
    input  mem_req, memWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
           ALUSrcA, ALUSrcB, ALUControl, regWriteEnable, regDst, memToReg,
           illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the shared-ALU, shared-memory multicycle datapath.
// Memory states stretch on mem_ready; reset zeroes every control output asynchronously.
module multicycle_control #(
  parameter logic [4:0] ALU_ADD     = 5'b00001,
  parameter logic [4:0] ALU_CMP_LEU = 5'b01000
) (
  input logic                  clock,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] EXEC_R    = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] EXEC_I    = 4'd8;
  localparam logic [3:0] I_WB      = 4'd9;
  localparam logic [3:0] BRANCH    = 4'd10;
  localparam logic [3:0] JUMP      = 4'd11;

  localparam logic [5:0] OP_ANDR = 6'b100000;
  localparam logic [5:0] OP_NORR = 6'b100110;
  localparam logic [5:0] OP_NOTR = 6'b000100;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic [5:0] op_s;

  assign op_s = bus.ins[31:26];

  // Dispatch target out of DECODE; FETCH here means the opcode is undefined.
  function automatic logic [3:0] decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                                 decode_next = MEM_ADDR;
      OP_ANDR, OP_NORR, OP_NOTR, OP_ROLV, OP_RORV:  decode_next = EXEC_R;
      OP_NORI:                                      decode_next = EXEC_I;
      OP_BLEU:                                      decode_next = BRANCH;
      OP_JR, OP_JAL:                                decode_next = JUMP;
      default:                                      decode_next = FETCH;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; mem_ready only matters in the three memory states.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH:     next_state_s = bus.mem_ready ? DECODE : FETCH;
      DECODE:    next_state_s = decode_next(op_s);
      MEM_ADDR:  next_state_s = (op_s == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  next_state_s = bus.mem_ready ? MEM_WB : MEM_READ;
      MEM_WB:    next_state_s = FETCH;
      MEM_WRITE: next_state_s = bus.mem_ready ? FETCH : MEM_WRITE;
      EXEC_R:    next_state_s = R_WB;
      R_WB:      next_state_s = FETCH;
      EXEC_I:    next_state_s = I_WB;
      I_WB:      next_state_s = FETCH;
      BRANCH:    next_state_s = FETCH;
      JUMP:      next_state_s = FETCH;
      default:   next_state_s = FETCH;
    endcase
  end

  assign bus.state = state_r;

  // Control outputs: decoded from state, forced low whenever reset is high.
  always_comb begin
    bus.mem_req        = 1'b0;
    bus.memWrite       = 1'b0;
    bus.IorD           = 1'b0;
    bus.IRWrite        = 1'b0;
    bus.PCWrite        = 1'b0;
    bus.PCWriteCond    = 1'b0;
    bus.PCSource       = 2'b00;
    bus.ALUSrcA        = 1'b0;
    bus.ALUSrcB        = 2'b00;
    bus.ALUControl     = 5'b00000;
    bus.regWriteEnable = 1'b0;
    bus.regDst         = 2'b00;
    bus.memToReg       = 2'b00;
    bus.illegal        = 1'b0;
    if (reset) begin
      bus.mem_req = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          bus.mem_req    = 1'b1;
          bus.ALUSrcB    = 2'b01;
          bus.ALUControl = ALU_ADD;
          bus.IRWrite    = bus.mem_ready;
          bus.PCWrite    = bus.mem_ready;
        end
        DECODE: begin
          bus.ALUSrcB    = 2'b11;
          bus.ALUControl = ALU_ADD;
          bus.illegal    = (decode_next(op_s) == FETCH);
        end
        MEM_ADDR: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUSrcB    = 2'b10;
          bus.ALUControl = ALU_ADD;
        end
        MEM_READ: begin
          bus.mem_req = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEM_WB: begin
          bus.regWriteEnable = 1'b1;
          bus.memToReg       = 2'b01;
        end
        MEM_WRITE: begin
          bus.mem_req  = 1'b1;
          bus.memWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        EXEC_R: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUControl = bus.ins[31:27];
        end
        R_WB: begin
          bus.regWriteEnable = 1'b1;
          bus.regDst         = 2'b01;
        end
        EXEC_I: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUSrcB    = 2'b10;
          bus.ALUControl = bus.ins[31:27];
        end
        I_WB: begin
          bus.regWriteEnable = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUControl  = ALU_CMP_LEU;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
        end
        JUMP: begin
          bus.PCWrite = 1'b1;
          // PC already holds PC+4, so jal links it straight into $31.
          if (op_s == OP_JAL) begin
            bus.PCSource       = 2'b10;
            bus.regWriteEnable = 1'b1;
            bus.regDst         = 2'b10;
            bus.memToReg       = 2'b10;
          end else begin
            bus.PCSource = 2'b11;
          end
        end
        default: begin
          bus.mem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: hand-computed state sequences and strobes
// per instruction class, memory wait stretching, illegal opcode and mid-wait reset.
module tb_multicycle_control;
  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] all_outs();
    all_outs = {bus.mem_req, bus.memWrite, bus.IorD, bus.IRWrite, bus.PCWrite,
                bus.PCWriteCond, bus.PCSource, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUControl, bus.regWriteEnable, bus.regDst, bus.memToReg,
                bus.illegal, bus.state};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.ins = 32'h0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outs", {6'd0, all_outs()}, 32'd0);
    reset = 1'b0;

    // lw, no waits: 0,1,2,3,4,0
    bus.ins = 32'h8C000000;
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_c1_state", bus.state, 32'd0);
    chk("lw_c1_req", bus.mem_req, 32'd1);
    chk("lw_c1_irw_pcw", {bus.IRWrite, bus.PCWrite}, 32'd3);
    chk("lw_c1_alu", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.PCSource}, {22'd0, 1'b0, 2'b01, 5'b00001, 2'b00});
    tick(); #1;
    chk("lw_c2_state", bus.state, 32'd1);
    chk("lw_c2_alu", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl}, {24'd0, 1'b0, 2'b11, 5'b00001});
    chk("lw_c2_irw", bus.IRWrite, 32'd0);
    tick(); #1;
    chk("lw_c3_state", bus.state, 32'd2);
    chk("lw_c3_alu", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl}, {24'd0, 1'b1, 2'b10, 5'b00001});
    tick(); #1;
    chk("lw_c4_state", bus.state, 32'd3);
    chk("lw_c4_mem", {bus.mem_req, bus.IorD, bus.memWrite, bus.regWriteEnable}, 32'b1100);
    tick(); #1;
    chk("lw_c5_state", bus.state, 32'd4);
    chk("lw_c5_wb", {bus.regWriteEnable, bus.regDst, bus.memToReg}, 32'b1_00_01);
    tick(); #1;
    chk("lw_end_state", bus.state, 32'd0);

    // andr with 3 FETCH wait cycles
    bus.ins = 32'h80000000;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("andr_wait", {bus.state, bus.mem_req, bus.IRWrite, bus.PCWrite, bus.IorD}, {4'd0, 4'b1000});
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("andr_ready", {bus.state, bus.mem_req, bus.IRWrite, bus.PCWrite}, {4'd0, 3'b111});
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("andr_decode", bus.state, 32'd1);
    tick(); #1;
    chk("andr_exec_state", bus.state, 32'd6);
    chk("andr_exec_alu", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl}, {24'd0, 1'b1, 2'b00, 5'b10000});
    tick(); #1;
    chk("andr_wb", {bus.state, bus.regWriteEnable, bus.regDst, bus.memToReg}, {4'd7, 1'b1, 2'b01, 2'b00});
    tick(); #1;
    chk("andr_end_state", bus.state, 32'd0);

    // sw with 2 MEM_WRITE wait cycles
    bus.ins = 32'hAC000000;
    bus.mem_ready = 1'b1;
    tick(); tick(); #1;
    chk("sw_addr_state", bus.state, 32'd2);
    bus.mem_ready = 1'b0;
    tick(); #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.mem_ready = 1'b1;
      #1;
      chk("sw_write", {bus.state, bus.mem_req, bus.memWrite, bus.IorD, bus.regWriteEnable}, {4'd5, 4'b1110});
      tick();
    end
    #1;
    chk("sw_end", {bus.state, bus.regWriteEnable}, {4'd0, 1'b0});

    // bleu: 0,1,10
    bus.ins = 32'h40000000;
    tick(); #1;
    chk("bleu_decode", bus.state, 32'd1);
    tick(); #1;
    chk("bleu_state", bus.state, 32'd10);
    chk("bleu_ctl", {bus.PCWriteCond, bus.PCSource, bus.ALUControl, bus.PCWrite, bus.ALUSrcA, bus.ALUSrcB},
        {20'd0, 1'b1, 2'b01, 5'b01000, 1'b0, 1'b1, 2'b00});
    tick(); #1;
    chk("bleu_end", bus.state, 32'd0);

    // jal then jr
    bus.ins = 32'h0C000000;
    tick(); tick(); #1;
    chk("jal_state", bus.state, 32'd11);
    chk("jal_ctl", {bus.PCWrite, bus.PCSource, bus.regWriteEnable, bus.regDst, bus.memToReg},
        {24'd0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10});
    tick(); #1;
    chk("jal_end", bus.state, 32'd0);
    bus.ins = 32'h20000000;
    tick(); tick(); #1;
    chk("jr_state", bus.state, 32'd11);
    chk("jr_ctl", {bus.PCWrite, bus.PCSource, bus.regWriteEnable, bus.regDst, bus.memToReg},
        {24'd0, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00});
    tick(); #1;

    // undefined opcode
    bus.ins = 32'hFC000000;
    chk("ill_fetch", bus.illegal, 32'd0);
    tick(); #1;
    chk("ill_decode", {bus.state, bus.illegal}, {4'd1, 1'b1});
    tick(); #1;
    chk("ill_after", {bus.state, bus.illegal}, {4'd0, 1'b0});

    // reset mid-wait in MEM_READ
    bus.ins = 32'h8C000000;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("rst_pre_state", {bus.state, bus.mem_req}, {4'd3, 1'b1});
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", {6'd0, all_outs()}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rel", {bus.state, bus.mem_req, bus.IRWrite}, {4'd0, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared-ALU, shared-memory multicycle datapath.
- Drives the multicycle strobes that the single-cycle decoder ties to 0: PCWrite, IorD, IRWrite, ALUSrcA, ALUSrcB. Also drives the register-file, memory and PC-source selects.
- Memory is accessed through a req/ready handshake, so fetch and load/store states can stretch for any number of wait cycles.

Parameters:
- ALU_ADD, 5'b00001: ALUControl code the ALU decodes as add. Used for PC+4, branch target and load/store address.
- ALU_CMP_LEU, 5'b01000: ALUControl code for the bleu compare (equals opcode bits [31:27] of bleu).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns FSM to FETCH.
- ins  in  32  instruction register contents; valid from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_req  out  1  memory access request.
- memWrite  out  1  write strobe; qualified by mem_req.
- IorD  out  1  0 = address from PC, 1 = address from ALUOut.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU compare true (bleu).
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28], ins[25:0], 2'b00}, 11 register rs.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 register B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm << 2.
- ALUControl  out  5  ALU operation.
- regWriteEnable  out  1  register-file write.
- regDst  out  2  00 rt, 01 rd, 10 $31 (link).
- memToReg  out  2  00 ALUOut, 01 MDR, 10 PC (link value).
- illegal  out  1  one-cycle pulse on an undefined opcode.
- state  out  4  current state encoding, for debug.

Behaviour:
- Opcode op = ins[31:26].
  - R-class: andr 100000, norr 100110, notr 000100, rolv 000000, rorv 000010.
  - lw 100011, sw 101011, nori 001110, bleu 010000, jr 001000, jal 000011.
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11. Codes 12-15 are unreachable and map to FETCH.
- While reset is high: state = FETCH and every output is forced to 0. Outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ALU_ADD, PCSource=00.
  - IRWrite and PCWrite are asserted only in the cycle mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ALU_ADD (precomputes branch target into ALUOut). Next state:
  - lw/sw -> MEM_ADDR
  - R-class -> EXEC_R
  - nori -> EXEC_I
  - bleu -> BRANCH
  - jr/jal -> JUMP
  - any other opcode -> FETCH, with illegal=1 for that cycle.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUControl=ALU_ADD. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_req=1, IorD=1. Wait until mem_ready=1, then -> MEM_WB.
- MEM_WB: regWriteEnable=1, regDst=00, memToReg=01; -> FETCH.
- MEM_WRITE: mem_req=1, memWrite=1, IorD=1. Wait until mem_ready=1, then -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUControl=ins[31:27]; -> R_WB.
- R_WB: regWriteEnable=1, regDst=01, memToReg=00; -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUControl=ins[31:27]; -> I_WB.
- I_WB: regWriteEnable=1, regDst=00, memToReg=00; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=ALU_CMP_LEU, PCWriteCond=1, PCSource=01; -> FETCH.
- JUMP:
  - Always: PCWrite=1.
  - jr: PCSource=11.
  - jal: PCSource=10, plus regWriteEnable=1, regDst=10, memToReg=10 (PC already holds PC+4).
  - -> FETCH.
- Instruction cycle counts at zero memory wait:
  - R-class, nori, sw: 4 cycles.
  - lw: 5 cycles.
  - bleu, jr, jal: 3 cycles.
  - Each cycle of mem_ready=0 adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- mem_req remains high and all address/control outputs remain stable throughout a wait. A mem_ready level seen outside FETCH, MEM_READ or MEM_WRITE is ignored.
- ins must not be sampled in FETCH; the IR updates at the end of the mem_ready cycle.
- Reset asserted mid-instruction, including during a memory wait: state returns to FETCH immediately and outputs go to 0 asynchronously. No partial register or memory write is issued after reset rises.
- Reset deassertion is synchronised externally. The first post-reset cycle is FETCH with mem_req=1.

Test Plan:
- Reset release, ins=0x8C000000 (lw), mem_ready=1 always -> state sequence 0,1,2,3,4,0. IRWrite=PCWrite=1 in cycle 1; regWriteEnable=1, memToReg=01 only in cycle 5.
- andr (ins=0x80000000), mem_ready held 0 for 3 cycles in FETCH -> state stays 0 for 4 cycles with mem_req=1, IRWrite=0 until the ready cycle. Then 1,6,7: EXEC_R has ALUControl=5'b10000; R_WB has regDst=01.
- sw (0xAC000000), mem_ready=0 for 2 cycles in MEM_WRITE -> memWrite=1, IorD=1 held for 3 cycles; return to FETCH after the ready cycle; regWriteEnable never asserts.
- bleu (0x40000000) -> states 0,1,10. BRANCH has PCWriteCond=1, PCSource=01, ALUControl=ALU_CMP_LEU, PCWrite=0.
- jal (0x0C000000) then jr (0x20000000) -> jal JUMP: PCWrite=1, PCSource=10, regWriteEnable=1, regDst=10, memToReg=10. jr JUMP: PCSource=11, regWriteEnable=0.
- Opcode 111111 -> illegal=1 for one cycle in DECODE, next state FETCH. Separately, reset asserted in MEM_READ mid-wait -> all outputs 0 within the same cycle; state=0.
